react_ctrl: RTL
===============

# react_ctrl

Round controller for the reaction timer, running on the 1 kHz system tick (1 clk = 1 ms). It turns the debounced start/stop key pulses and the stimulus-LED level into the `flag[2:0]` round code that drives the LED stage. It measures the reaction time in milliseconds and keeps the best result since reset. The stimulus LED's `led[2]` output feeds back into this block as `stim_on`.

## Interface
- `CNT_W`, 14: width of the millisecond counters and result outputs.
- `MAX_MS`, 9999: reaction timeout in ms. Also the saturation value and the reset value of `best_ms`.
- `ARM_MAX`, 8000: the longest time, in ms, spent armed without a stimulus edge before the round is abandoned.

- `clk`  in  1  system clock, 1 kHz.
- `rst`  in  1  one clock; reset is asynchronous and active-low (low = reset).
- `start`  in  1  single-cycle debounced start-key pulse.
- `stop`  in  1  single-cycle debounced reaction-key pulse.
- `stim_on`  in  1  stimulus LED level from the LED stage.
- `flag`  out  3  round code: 0 idle, 1 armed/measuring, 2 valid result, 3 fault.
- `rt_ms`  out  CNT_W  last reaction time in ms.
- `rt_valid`  out  1  one-cycle pulse when `rt_ms` is updated with a valid result.
- `best_ms`  out  CNT_W  minimum valid `rt_ms` since reset.
- `fault`  out  2  01 false start, 10 timeout, 00 none.

## Operation
- The state machine has five states. Each state drives a fixed `flag` value:
  - IDLE drives 0.
  - ARMED drives 1.
  - MEAS drives 1.
  - RESULT drives 2.
  - FAULT drives 3.
- Stimulus edge detect:
  - `stim_d` is a register of `stim_on`, updated every cycle in every state, reset value 0.
  - `edge = stim_on & ~stim_d`.
  - A stimulus that is already high produces no edge. It must go low before a new edge is recognised.
- IDLE:
  - `start` -> ARMED; arm counter cleared to 0.
  - `stop` is ignored.
- ARMED:
  - `stop` -> FAULT, `fault`=01. This applies even if `edge` is asserted in the same cycle (false start wins).
  - Else `edge` -> MEAS; measure counter cleared to 0.
  - Else, when the arm counter reaches ARM_MAX-1 -> IDLE, no fault.
  - Else the arm counter increments.
  - `start` is ignored.
- MEAS:
  - `stop` sampled in the n-th MEAS cycle (n=1 for the first) -> RESULT, with `rt_ms`=n and `rt_valid` pulsed.
  - When n=MAX_MS and no `stop` -> FAULT, `fault`=10, `rt_ms`=MAX_MS, no `rt_valid`.
  - `stop` at n=MAX_MS -> RESULT with `rt_ms`=MAX_MS (stop wins over timeout).
  - `start` is ignored.
- RESULT:
  - On the entry edge, `best_ms` <= min(`best_ms`, new `rt_ms`). A tie leaves `best_ms` unchanged.
  - Outputs are held until `start`, then -> ARMED.
- FAULT:
  - Outputs are held until `start`, then -> ARMED with `fault` cleared.
  - `rt_ms` keeps its previous value on a false start.
- Arithmetic rules:
  - Counters are unsigned CNT_W-bit values and never wrap; the transitions above bound them.
  - `rt_ms` is always in the range 1..MAX_MS after the first round.
- Simultaneous `start` and `stop`:
  - In IDLE, RESULT and FAULT, `start` wins and `stop` is dropped.
  - In ARMED and MEAS, `stop` is honoured and `start` is ignored.

## Timing
- Reset values: state IDLE, `flag`=0, `rt_ms`=0, `rt_valid`=0, `best_ms`=MAX_MS, `fault`=00, `stim_d`=0, counters 0.
- Reset asserted mid-round returns every output to its reset value immediately (asynchronous). The first transition is possible on the first rising edge after `rst` goes high.
- All outputs are registered. `flag`, `fault`, `rt_ms`, `rt_valid` and `best_ms` change on the same edge that samples the causing input, and are visible one cycle after the input pulse.
- Stimulus latency: a `stim_on` rise sampled at edge k gives `edge`=1 in cycle k. The block is in MEAS from edge k+1, so that cycle is n=1.
- `rt_valid` is high for exactly one cycle, coincident with the first RESULT cycle.

## Test plan
- Normal round: `start`; `stim_on` rises 3000 cycles later; `stop` 250 cycles after the rise -> `flag` goes 0 -> 1 -> 2, `rt_ms`=250, one-cycle `rt_valid`, `best_ms`=250.
- False start: `start`, then `stop` before `stim_on` rises -> `flag`=3, `fault`=01, `rt_ms` unchanged, `best_ms` unchanged. Then `start` -> `flag`=1, `fault`=00.
- Timeout and boundary:
  - With MAX_MS=20, no `stop` after the edge -> `flag`=3, `fault`=10, `rt_ms`=20, no `rt_valid`.
  - `stop` on MEAS cycle 20 -> `flag`=2, `rt_ms`=20.
- Best tracking: rounds with reactions 400, 300, 350, 300 -> `best_ms` reads 400, 300, 300, 300. `rt_valid` pulses four times.
- Corner cases:
  - `stop` in the same cycle as the `stim_on` rise -> false start.
  - `start` together with `stop` in IDLE -> ARMED.
  - `stim_on` held high across `start` -> no MEAS; after ARM_MAX cycles -> IDLE.
- Reset: `rst` low for 2 cycles during MEAS at n=100 -> all outputs return to reset values immediately. The next `start` begins a clean round.

Source files
------------

// File: rtl/react_ctrl.sv
// Reaction-timer round controller: arms on start, measures ms from stimulus edge to stop, tracks best.
// Latency: all outputs registered, visible one cycle after the causing input is sampled.
// Backpressure: none; start/stop are single-cycle pulses and are consumed or dropped per state.
module react_ctrl #(
    parameter int CNT_W   = 14,
    parameter int MAX_MS  = 9999,
    parameter int ARM_MAX = 8000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             stim_on,
    output logic [2:0]       flag,
    output logic [CNT_W-1:0] rt_ms,
    output logic             rt_valid,
    output logic [CNT_W-1:0] best_ms,
    output logic [1:0]       fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_MEAS   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_MAX - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       flag_nxt;
    logic             stim_d;
    logic             stim_edge;
    logic [CNT_W-1:0] arm_cnt;
    logic [CNT_W-1:0] meas_cnt;
    logic [CNT_W-1:0] meas_n;

    // A stimulus already high when armed never counts; it must drop first.
    assign stim_edge = stim_on & ~stim_d;
    // meas_cnt is cleared on MEAS entry, so the current MEAS cycle number is one more.
    assign meas_n    = meas_cnt + CNT_W'(1);

    // Stimulus level history for rising-edge detection, tracked in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stim_d <= 1'b0;
        end else begin
            stim_d <= stim_on;
        end
    end

    // Next-state selection; stop beats edge in ARMED, stop beats timeout in MEAS.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (stop)                     state_nxt = S_FAULT;
                else if (stim_edge)           state_nxt = S_MEAS;
                else if (arm_cnt == ARM_LAST) state_nxt = S_IDLE;
            end
            S_MEAS: begin
                if (stop)                 state_nxt = S_RESULT;
                else if (meas_n == MAX_V) state_nxt = S_FAULT;
            end
            S_RESULT, S_FAULT: begin
                if (start) state_nxt = S_ARMED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round code for the LED stage, registered alongside the state.
    always_comb begin
        flag_nxt = 3'd0;
        case (state_nxt)
            S_ARMED, S_MEAS: flag_nxt = 3'd1;
            S_RESULT:        flag_nxt = 3'd2;
            S_FAULT:         flag_nxt = 3'd3;
            default:         flag_nxt = 3'd0;
        endcase
    end

    // State, counters and result registers; outputs update on the edge that samples their cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            flag     <= 3'd0;
            arm_cnt  <= '0;
            meas_cnt <= '0;
            rt_ms    <= '0;
            rt_valid <= 1'b0;
            best_ms  <= MAX_V;
            fault    <= 2'b00;
        end else begin
            state    <= state_nxt;
            flag     <= flag_nxt;
            rt_valid <= 1'b0;
            case (state)
                S_IDLE, S_RESULT, S_FAULT: begin
                    if (start) begin
                        arm_cnt <= '0;
                        fault   <= 2'b00;
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        fault <= 2'b01;
                    end else if (stim_edge) begin
                        meas_cnt <= '0;
                    end else if (arm_cnt != ARM_LAST) begin
                        arm_cnt <= arm_cnt + CNT_W'(1);
                    end
                end
                S_MEAS: begin
                    if (stop) begin
                        rt_ms    <= meas_n;
                        rt_valid <= 1'b1;
                        if (meas_n < best_ms) best_ms <= meas_n;
                    end else if (meas_n == MAX_V) begin
                        fault <= 2'b10;
                        rt_ms <= MAX_V;
                    end else begin
                        meas_cnt <= meas_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
